// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake bundle between an issuing controller and the
// sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int SIZE = 15
);
  logic            start;
  logic [SIZE:0]   dividend;
  logic [SIZE:0]   divisor;
  logic            busy;
  logic            done;
  logic [SIZE:0]   quotient;
  logic [SIZE:0]   remainder;
  logic            div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock. Each trial
// subtraction is an add of the inverted divisor with carry-in 1.
module seq_restoring_divider #(
  parameter int SIZE = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int AW = SIZE + 2;
  localparam int CW = (SIZE > 0) ? $clog2(SIZE + 1) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            busy_q;
  logic            done_q;
  logic            dbz_q;
  logic [SIZE:0]   quo_q;
  logic [SIZE:0]   rem_q;
  logic [CW-1:0]   cnt_q;

  logic [AW-1:0]   a_q;
  logic [SIZE:0]   q_q;
  logic [SIZE:0]   m_q;

  logic [AW-1:0]   a_sh;
  logic [SIZE:0]   q_sh;
  logic [AW:0]     trial;
  logic            no_borrow;
  logic [AW-1:0]   a_nx;
  logic [SIZE:0]   q_nx;
  logic            accept;

  // {carry_out, difference} of a - m computed as a + ~{0,m} + 1.
  function automatic logic [AW:0] trial_sub(input logic [AW-1:0] a,
                                            input logic [SIZE:0] m);
    return {1'b0, a} + {1'b0, ~{1'b0, m}} + (AW+1)'(1);
  endfunction

  // The cycle carrying the done pulse is treated as part of DONE, so a
  // start held across it is only taken on the following cycle.
  assign accept = (state == IDLE) && bus.start && !done_q;

  always_comb begin
    a_sh      = {a_q[AW-2:0], q_q[SIZE]};
    q_sh      = q_q << 1;
    trial     = trial_sub(a_sh, m_q);
    no_borrow = trial[AW];
    a_nx      = no_borrow ? trial[AW-1:0] : a_sh;
    q_nx      = {q_sh[SIZE:1], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.divisor == '0) begin
              state <= DONE;
              quo_q <= '1;
              rem_q <= bus.dividend;
              dbz_q <= 1'b1;
            end else begin
              state  <= CALC;
              busy_q <= 1'b1;
              cnt_q  <= CW'(SIZE);
            end
          end
        end
        CALC: begin
          if (cnt_q == '0) begin
            state  <= DONE;
            busy_q <= 1'b0;
            quo_q  <= q_nx;
            rem_q  <= a_nx[SIZE:0];
            dbz_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working registers carry data only; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= '0;
      q_q <= bus.dividend;
      m_q <= bus.divisor;
    end else if (state == CALC) begin
      a_q <= a_nx;
      q_q <= q_nx;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of seq_restoring_divider: results, latency,
// busy/done handshake, ignored starts, reset abort and result hold.
module tb_seq_restoring_divider;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  seq_restoring_divider_if #(.SIZE(15)) dif ();

  seq_restoring_divider #(.SIZE(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input logic [15:0] dd, input logic [15:0] dv,
                         input bit intrude);
    logic [15:0] eq, er, prev_q, prev_r;
    logic        edbz;
    int          k, busy_cnt;
    k = 0;
    while ((dif.busy || dif.done) && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check_eq("idle_wait", 32'(k < 50), 32'd1);
    if (dv == 16'd0) begin
      eq = 16'hFFFF; er = dd; edbz = 1'b1;
    end else begin
      eq = dd / dv; er = dd % dv; edbz = 1'b0;
    end
    prev_q = dif.quotient;
    prev_r = dif.remainder;
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = dd; dif.divisor = dv;
    @(posedge clk); #1;
    dif.start = 1'b0; dif.dividend = 16'hDEAD; dif.divisor = 16'h0003;
    busy_cnt = int'(dif.busy);
    if (dv != 16'd0) begin
      check_eq("hold_q_calc", 32'(dif.quotient), 32'(prev_q));
      check_eq("hold_r_calc", 32'(dif.remainder), 32'(prev_r));
    end
    k = 0;
    while (!dif.done && k < 40) begin
      if (intrude && k == 4) begin
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 16'd9; dif.divisor = 16'd2;
        @(posedge clk); #1;
        dif.start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      k++;
      busy_cnt += int'(dif.busy);
    end
    check_eq("latency", 32'(k), (dv == 16'd0) ? 32'd1 : 32'd17);
    check_eq("busy_cycles", 32'(busy_cnt), (dv == 16'd0) ? 32'd0 : 32'd16);
    check_eq("quotient", 32'(dif.quotient), 32'(eq));
    check_eq("remainder", 32'(dif.remainder), 32'(er));
    check_eq("div_by_zero", 32'(dif.div_by_zero), 32'(edbz));
    @(posedge clk); #1;
    check_eq("done_pulse", 32'(dif.done), 32'd0);
    check_eq("hold_q_after", 32'(dif.quotient), 32'(eq));
    check_eq("hold_r_after", 32'(dif.remainder), 32'(er));
  endtask

  initial begin
    int dcount;
    logic [15:0] rdd, rdv;
    n_vec = 0;
    n_miss = 0;
    rst_n = 1'b0;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(dif.busy), 32'd0);
    check_eq("rst_done", 32'(dif.done), 32'd0);
    check_eq("rst_q", 32'(dif.quotient), 32'd0);
    check_eq("rst_r", 32'(dif.remainder), 32'd0);
    check_eq("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_div(16'd100, 16'd7, 1'b0);
    run_div(16'hFFFF, 16'd1, 1'b0);
    run_div(16'hFFFF, 16'hFFFF, 1'b0);
    run_div(16'd3, 16'd10, 1'b0);
    run_div(16'd5, 16'd0, 1'b0);
    run_div(16'd100, 16'd7, 1'b1);
    run_div(16'd9, 16'd2, 1'b0);

    // Abort a calculation with an asynchronous reset mid-CALC.
    @(negedge clk);
    dif.start = 1'b1; dif.dividend = 16'd100; dif.divisor = 16'd7;
    @(posedge clk); #1;
    dif.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(dif.busy), 32'd0);
    check_eq("abort_done", 32'(dif.done), 32'd0);
    check_eq("abort_q", 32'(dif.quotient), 32'd0);
    check_eq("abort_r", 32'(dif.remainder), 32'd0);
    check_eq("abort_dbz", 32'(dif.div_by_zero), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      dcount += int'(dif.done);
    end
    check_eq("abort_no_done", 32'(dcount), 32'd0);
    run_div(16'd50, 16'd5, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      rdd = (i % 11 == 0) ? 16'd0 : 16'($urandom);
      if (i % 13 == 0)      rdv = 16'd0;
      else if (i % 3 == 0)  rdv = 16'($urandom_range(1, 255));
      else                  rdv = 16'($urandom);
      run_div(rdd, rdv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
